// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment scan controller: shadow/active digit banks with a
// once-per-frame tear-free commit, blanking gaps between digits, and registered outputs.
module seg_scan_controller #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_CYCLES  = 16,
    parameter bit EN_ACTIVE_LOW = 1'b1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IW-1:0]         wr_digit,
    input  logic [3:0]            wr_code,
    input  logic                  wr_blank,
    output logic [3:0]            code,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [IW-1:0]         scan_idx,
    output logic                  frame_tick
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{EN_ACTIVE_LOW}};

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [IW-1:0]               scan_d;
    logic                        commit;
    logic                        wr_fire;

    logic [NUM_DIGITS-1:0][3:0]  sh_code_q, sh_code_d;
    logic [NUM_DIGITS-1:0]       sh_blank_q, sh_blank_d;
    logic [NUM_DIGITS-1:0][3:0]  act_code_q, act_code_d;
    logic [NUM_DIGITS-1:0]       act_blank_q, act_blank_d;

    logic                        lit;
    logic [NUM_DIGITS-1:0]       onehot;
    logic [NUM_DIGITS-1:0]       dig_en_d;
    logic [3:0]                  code_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        scan_d  = scan_idx;
        commit  = 1'b0;
        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    commit  = (scan_idx == '0);
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    scan_d  = (scan_idx == LAST_IDX) ? '0 : scan_idx + IW'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Out-of-range digit indices complete the handshake but never touch the shadow bank.
    always_comb begin
        wr_fire    = wr_valid && wr_ready && (int'(wr_digit) < NUM_DIGITS);
        sh_code_d  = sh_code_q;
        sh_blank_d = sh_blank_q;
        if (wr_fire) begin
            sh_code_d[wr_digit]  = wr_code;
            sh_blank_d[wr_digit] = wr_blank;
        end
        // A write landing on the commit edge is folded into the newly committed frame.
        act_code_d  = commit ? sh_code_d  : act_code_q;
        act_blank_d = commit ? sh_blank_d : act_blank_q;
    end

    always_comb begin
        lit      = (state_d == ST_SHOW) && !act_blank_d[scan_d];
        onehot   = NUM_DIGITS'(1) << scan_d;
        dig_en_d = lit ? (EN_ACTIVE_LOW ? ~onehot : onehot) : ALL_OFF;
        code_d   = act_code_d[scan_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            scan_idx    <= '0;
            sh_code_q   <= '0;
            sh_blank_q  <= '1;
            act_code_q  <= '0;
            act_blank_q <= '1;
            code        <= '0;
            dig_en      <= ALL_OFF;
            frame_tick  <= 1'b0;
            wr_ready    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scan_idx    <= scan_d;
            sh_code_q   <= sh_code_d;
            sh_blank_q  <= sh_blank_d;
            act_code_q  <= act_code_d;
            act_blank_q <= act_blank_d;
            code        <= code_d;
            dig_en      <= dig_en_d;
            frame_tick  <= commit;
            wr_ready    <= !commit;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed and random writes checked every cycle
// against a frame/slot arithmetic model of the display.
module tb_seg_scan_controller;

    localparam int ND     = 4;
    localparam int RD     = 4;
    localparam int BC     = 2;
    localparam int SLOT   = RD + BC;
    localparam int FRAME  = ND * SLOT;
    localparam int FRAME2 = 3 * SLOT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       wr_valid, wr_ready, wr_blank;
    logic [1:0] wr_digit;
    logic [3:0] wr_code;
    logic [3:0] code;
    logic [3:0] dig_en;
    logic [1:0] scan_idx;
    logic       frame_tick;

    logic       wr_valid2, wr_ready2, wr_blank2;
    logic [1:0] wr_digit2;
    logic [3:0] wr_code2;
    logic [3:0] code2;
    logic [2:0] dig_en2;
    logic [1:0] scan_idx2;
    logic       frame_tick2;

    seg_scan_controller #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .EN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_digit(wr_digit), .wr_code(wr_code), .wr_blank(wr_blank),
        .code(code), .dig_en(dig_en), .scan_idx(scan_idx), .frame_tick(frame_tick)
    );

    seg_scan_controller #(
        .NUM_DIGITS(3), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .EN_ACTIVE_LOW(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
        .wr_digit(wr_digit2), .wr_code(wr_code2), .wr_blank(wr_blank2),
        .code(code2), .dig_en(dig_en2), .scan_idx(scan_idx2), .frame_tick(frame_tick2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: shadow/active banks plus cycle count since the last reset edge.
    logic [3:0] sh_code [ND];
    logic [3:0] ac_code [ND];
    bit         sh_blank[ND];
    bit         ac_blank[ND];
    int         k      = 0;
    bit         mvalid = 1'b0;
    bit         acc    = 1'b0;

    function automatic bit exp_ready(input int kk);
        return (kk != 0) && (kk % FRAME != BC);
    endfunction

    task automatic check_now();
        int ph, slot, ph2;
        bit lit;
        logic [3:0] one, exp_en;
        if (!mvalid) return;
        ph     = k % FRAME;
        slot   = ph / SLOT;
        lit    = (ph % SLOT >= BC) && !ac_blank[slot];
        one    = 4'b0001 << slot;
        exp_en = lit ? ~one : 4'b1111;
        ph2    = k % FRAME2;

        checks++;
        assert (code === ac_code[slot]) else begin
            failures++; $error("FAIL code k=%0d got=%h exp=%h", k, code, ac_code[slot]);
        end
        checks++;
        assert (dig_en === exp_en) else begin
            failures++; $error("FAIL dig_en k=%0d got=%b exp=%b", k, dig_en, exp_en);
        end
        checks++;
        assert (scan_idx === 2'(slot)) else begin
            failures++; $error("FAIL scan_idx k=%0d got=%0d exp=%0d", k, scan_idx, slot);
        end
        checks++;
        assert (frame_tick === (ph == BC)) else begin
            failures++; $error("FAIL frame_tick k=%0d got=%b exp=%b", k, frame_tick, (ph == BC));
        end
        checks++;
        assert (wr_ready === exp_ready(k)) else begin
            failures++; $error("FAIL wr_ready k=%0d got=%b exp=%b", k, wr_ready, exp_ready(k));
        end

        checks++;
        assert (code2 === 4'h0 && dig_en2 === 3'b111) else begin
            failures++; $error("FAIL dut3_display k=%0d got=%h/%b exp=0/111", k, code2, dig_en2);
        end
        checks++;
        assert (scan_idx2 === 2'(ph2 / SLOT) && frame_tick2 === (ph2 == BC)) else begin
            failures++; $error("FAIL dut3_scan k=%0d got=%0d/%b exp=%0d/%b",
                               k, scan_idx2, frame_tick2, ph2 / SLOT, (ph2 == BC));
        end
        checks++;
        assert (wr_ready2 === ((k != 0) && (ph2 != BC))) else begin
            failures++; $error("FAIL dut3_ready k=%0d got=%b exp=%b", k, wr_ready2, ((k != 0) && (ph2 != BC)));
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_now();
        @(posedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < ND; i++) begin
                sh_code[i] = 4'h0; sh_blank[i] = 1'b1;
                ac_code[i] = 4'h0; ac_blank[i] = 1'b1;
            end
            k      = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (wr_valid && exp_ready(k)) begin
                acc = 1'b1;
                sh_code[wr_digit]  = wr_code;
                sh_blank[wr_digit] = wr_blank;
            end
            k++;
            if (k % FRAME == BC) begin
                for (int i = 0; i < ND; i++) begin
                    ac_code[i]  = sh_code[i];
                    ac_blank[i] = sh_blank[i];
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic write(input logic [1:0] d, input logic [3:0] c, input logic b);
        wr_digit = d; wr_code = c; wr_blank = b; wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (acc) break;
        end
        wr_valid = 1'b0;
        checks++;
        assert (acc) else begin
            failures++; $error("FAIL handshake_timeout got=0 exp=1 digit=%0d", d);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_digit = '0; wr_code = '0; wr_blank = 1'b0;
        wr_valid2 = 1'b0; wr_digit2 = '0; wr_code2 = '0; wr_blank2 = 1'b0;
        for (int i = 0; i < ND; i++) begin
            sh_code[i] = 4'h0; sh_blank[i] = 1'b1; ac_code[i] = 4'h0; ac_blank[i] = 1'b1;
        end

        repeat (3) step();
        rst_n = 1'b1;
        idle(FRAME + 2);

        idle(8);
        write(2'd0, 4'h3, 1'b0);
        write(2'd2, 4'hA, 1'b0);
        idle(FRAME * 2);

        write(2'd1, 4'h7, 1'b1);
        idle(FRAME + SLOT);

        for (int i = 0; i < 2 * FRAME && (k % FRAME != BC); i++) step();
        write(2'd3, 4'h5, 1'b0);
        idle(FRAME * 2);

        for (int i = 0; i < 4 && (k % FRAME2 == BC || k % FRAME2 == BC - 1); i++) step();
        wr_valid2 = 1'b1; wr_digit2 = 2'd3; wr_code2 = 4'hF; wr_blank2 = 1'b0;
        step();
        wr_valid2 = 1'b0;
        idle(FRAME2 * 2);

        repeat (200) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_valid = 1'b1;
                wr_digit = 2'($urandom_range(0, 3));
                wr_code  = 4'($urandom_range(0, 15));
                wr_blank = ($urandom_range(0, 3) == 0);
            end else begin
                wr_valid = 1'b0;
            end
            step();
        end
        idle(FRAME);

        for (int i = 0; i < 2 * FRAME && !(((k % FRAME) / SLOT == 2) && ((k % FRAME) % SLOT >= BC)); i++)
            step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(FRAME * 2 + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
